floor_call_memory: RTL and testbench

Request memory on the consumer side of the floor-call comparator. It stores pending floor calls in a circular double-ended queue, inserting each call at the front or back as the comparator directs, and retires the head when the car reaches it. It supplies the head floor (pos0Mem) and the travel direction (down_up_Flag) that the comparator uses for its next decision. It sits between the comparator and the motor/door controller.

---
 rtl/elevator_pkg.sv | 28 ++
 rtl/floor_match_cam.sv | 37 +++
 rtl/floor_call_memory.sv | 139 +++++++++++++
 tb/tb_floor_call_memory.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg
//   Shared definitions for the elevator request path: floor width, the
//   comparator's insert-position flag encodings, direction encodings and
//   the decoded insert kind used inside the call memory.
package elevator_pkg;

  localparam int FLOOR_W = 3;

  // BeginEndMemory_Flag encodings; bit 1 clear means "no insert".
  localparam logic [1:0] MEM_BEGIN = 2'b11;
  localparam logic [1:0] MEM_END   = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    INS_NONE  = 2'd0,
    INS_FRONT = 2'd1,
    INS_BACK  = 2'd2
  } ins_kind_e;

  // Decode the comparator flag qualified by its strobe.
  function automatic ins_kind_e decode_ins(input logic valid, input logic [1:0] flag);
    if (!valid || !flag[1]) return INS_NONE;
    return (flag == MEM_BEGIN) ? INS_FRONT : INS_BACK;
  endfunction

endpackage

// File: rtl/floor_match_cam.sv
// floor_match_cam
//   Combinational DEPTH-way comparison of a candidate floor against the
//   occupied window of the circular queue (slots head .. head+count-1,
//   modulo DEPTH).
// Ports:
//   entries  in   DEPTH x FLOOR_W  raw queue storage
//   head     in   PTR_W            index of the oldest (front) entry
//   count    in   PTR_W+1          number of occupied slots
//   floor    in   FLOOR_W          candidate floor
//   hit      out  1                candidate equals some occupied entry
module floor_match_cam
  import elevator_pkg::*;
#(
  parameter int   FLOOR_W = elevator_pkg::FLOOR_W,
  parameter int   DEPTH   = 8,
  localparam int  PTR_W   = $clog2(DEPTH)
) (
  input  logic [FLOOR_W-1:0] entries [DEPTH],
  input  logic [PTR_W-1:0]   head,
  input  logic [PTR_W:0]     count,
  input  logic [FLOOR_W-1:0] floor,
  output logic               hit
);

  logic [DEPTH-1:0] slot_hit;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    // Distance of this slot from the head; the subtraction wraps modulo
    // DEPTH because DEPTH is a power of two.
    logic [PTR_W-1:0] offs;
    assign offs        = PTR_W'(g) - head;
    assign slot_hit[g] = ({1'b0, offs} < count) && (entries[g] == floor);
  end

  assign hit = |slot_hit;

endmodule

// File: rtl/floor_call_memory.sv
// floor_call_memory
//   Pending floor-call store between the floor-call comparator and the
//   motor/door controller. Calls live in a circular double-ended queue;
//   the comparator chooses front or back insertion, and the head is
//   retired when the car stops at it.
//
//   Strobe protocol: callValid and floorReached are single-cycle strobes
//   with no back-pressure. Every strobe is consumed on the edge it is
//   sampled. A rejected insert (duplicate or no room) is reported one
//   cycle later by a single-cycle callDropped pulse; there is no retry.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   callValid             insert strobe
//   nextMemoryFloor       floor to insert
//   BeginEndMemory_Flag   11 front, 10 back, 0x no insert
//   floorReached          pop strobe (car stopped at pos0Mem)
//   actualFloor           current car floor
//   pos0Mem               head floor, 0 when empty
//   down_up_Flag          travel direction, 1 up / 0 down
//   memEmpty, memFull     occupancy flags decoded from count
//   callDropped           pulse after a rejected insert
//   count                 number of stored entries
module floor_call_memory
  import elevator_pkg::*;
#(
  parameter int   FLOOR_W = elevator_pkg::FLOOR_W,
  parameter int   DEPTH   = 8,
  localparam int  PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               callValid,
  input  logic [FLOOR_W-1:0] nextMemoryFloor,
  input  logic [1:0]         BeginEndMemory_Flag,
  input  logic               floorReached,
  input  logic [FLOOR_W-1:0] actualFloor,
  output logic [FLOOR_W-1:0] pos0Mem,
  output logic               down_up_Flag,
  output logic               memEmpty,
  output logic               memFull,
  output logic               callDropped,
  output logic [PTR_W:0]     count
);

  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

  logic [FLOOR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W:0]     count_q;
  logic               dir_q;
  logic               drop_q;

  // "_p" = state after the pop, "_n" = state after the insert.
  logic [PTR_W-1:0]   head_p, head_n, wr_idx;
  logic [PTR_W:0]     count_p, count_n;
  logic               do_pop, do_ins, drop;
  logic               dup_hit, empty_dup, full_p;
  ins_kind_e          ins_kind;
  logic [FLOOR_W-1:0] head_val_n;
  logic               dir_n;

  // Duplicate search runs against the post-pop window, so a call for the
  // floor being retired this cycle is accepted again.
  floor_match_cam #(
    .FLOOR_W (FLOOR_W),
    .DEPTH   (DEPTH)
  ) u_cam (
    .entries (mem),
    .head    (head_p),
    .count   (count_p),
    .floor   (nextMemoryFloor),
    .hit     (dup_hit)
  );

  always_comb begin
    do_pop  = floorReached && (count_q != '0);
    head_p  = do_pop ? head_q + PTR_W'(1) : head_q;
    count_p = do_pop ? count_q - (PTR_W+1)'(1) : count_q;

    ins_kind  = decode_ins(callValid, BeginEndMemory_Flag);
    // With nothing left queued, a call for the floor the car is on is moot.
    empty_dup = (count_p == '0) && (nextMemoryFloor == actualFloor);
    full_p    = (count_p == COUNT_FULL);
    drop      = (ins_kind != INS_NONE) && (dup_hit || empty_dup || full_p);
    do_ins    = (ins_kind != INS_NONE) && !drop;

    head_n  = head_p;
    count_n = count_p;
    wr_idx  = head_p + count_p[PTR_W-1:0];
    if (do_ins) begin
      count_n = count_p + (PTR_W+1)'(1);
      if (ins_kind == INS_FRONT) begin
        head_n = head_p - PTR_W'(1);
        wr_idx = head_p - PTR_W'(1);
      end
    end

    // Head value as it will be after this edge, including a write that
    // lands on the new head slot.
    head_val_n = (do_ins && (wr_idx == head_n)) ? nextMemoryFloor : mem[head_n];

    dir_n = dir_q;
    if (count_n != '0) begin
      if (head_val_n > actualFloor)      dir_n = DIR_UP;
      else if (head_val_n < actualFloor) dir_n = DIR_DOWN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_ins) begin
      mem[wr_idx] <= nextMemoryFloor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      count_q <= '0;
      dir_q   <= DIR_DOWN;
      drop_q  <= 1'b0;
    end else begin
      head_q  <= head_n;
      count_q <= count_n;
      dir_q   <= dir_n;
      drop_q  <= drop;
    end
  end

  assign pos0Mem      = (count_q != '0) ? mem[head_q] : '0;
  assign down_up_Flag = dir_q;
  assign memEmpty     = (count_q == '0);
  assign memFull      = (count_q == COUNT_FULL);
  assign callDropped  = drop_q;
  assign count        = count_q;

endmodule

// File: tb/tb_floor_call_memory.sv
// tb_floor_call_memory
//   Directed bench for floor_call_memory with hand-computed expectations.
module tb_floor_call_memory;
  import elevator_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic               clk;
  logic               rst_n;
  logic               callValid;
  logic [FLOOR_W-1:0] nextMemoryFloor;
  logic [1:0]         BeginEndMemory_Flag;
  logic               floorReached;
  logic [FLOOR_W-1:0] actualFloor;
  logic [FLOOR_W-1:0] pos0Mem;
  logic               down_up_Flag;
  logic               memEmpty;
  logic               memFull;
  logic               callDropped;
  logic [PTR_W:0]     count;

  int n_checks;
  int n_errors;

  // Expected head sequence for drain checks, loaded by hand.
  logic [FLOOR_W-1:0] exp_q[$];

  floor_call_memory #(.FLOOR_W(FLOOR_W), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .callValid           (callValid),
    .nextMemoryFloor     (nextMemoryFloor),
    .BeginEndMemory_Flag (BeginEndMemory_Flag),
    .floorReached        (floorReached),
    .actualFloor         (actualFloor),
    .pos0Mem             (pos0Mem),
    .down_up_Flag        (down_up_Flag),
    .memEmpty            (memEmpty),
    .memFull             (memFull),
    .callDropped         (callDropped),
    .count               (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs are applied 1ns after a rising edge; outputs are sampled at the
  // same point after the next rising edge.
  task automatic step(input logic cv, input logic [1:0] flag,
                      input logic [FLOOR_W-1:0] fl, input logic fr);
    callValid           = cv;
    BeginEndMemory_Flag = flag;
    nextMemoryFloor     = fl;
    floorReached        = fr;
    @(posedge clk);
    #1;
    callValid           = 1'b0;
    BeginEndMemory_Flag = 2'b00;
    floorReached        = 1'b0;
  endtask

  task automatic push_back(input logic [FLOOR_W-1:0] fl);
    step(1'b1, MEM_END, fl, 1'b0);
  endtask

  task automatic push_front(input logic [FLOOR_W-1:0] fl);
    step(1'b1, MEM_BEGIN, fl, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 2'b00, '0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 2'b00, '0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pop everything in exp_q, checking the head before each pop.
  task automatic drain(input string tag);
    logic [FLOOR_W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_head"}, 32'(pos0Mem), 32'(e));
      pop();
    end
    check({tag, "_empty"}, 32'(memEmpty), 32'd1);
    check({tag, "_pos0"},  32'(pos0Mem),  32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks            = 0;
    n_errors            = 0;
    rst_n               = 1'b0;
    callValid           = 1'b0;
    nextMemoryFloor     = '0;
    BeginEndMemory_Flag = 2'b00;
    floorReached        = 1'b0;
    actualFloor         = '0;

    #12;
    check("rst_count", 32'(count),        32'd0);
    check("rst_pos0",  32'(pos0Mem),      32'd0);
    check("rst_empty", 32'(memEmpty),     32'd1);
    check("rst_full",  32'(memFull),      32'd0);
    check("rst_drop",  32'(callDropped),  32'd0);
    check("rst_dir",   32'(down_up_Flag), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: first insert at back
    actualFloor = 3'd0;
    push_back(3'd3);
    check("t1_count", 32'(count),    32'd1);
    check("t1_pos0",  32'(pos0Mem),  32'd3);
    check("t1_empty", 32'(memEmpty), 32'd0);
    idle();
    check("t1_dir",   32'(down_up_Flag), 32'd1);

    // 2: [3,5] then front insert of 1 -> [1,3,5]
    push_back(3'd5);
    check("t2_count2", 32'(count),   32'd2);
    check("t2_pos0a",  32'(pos0Mem), 32'd3);
    actualFloor = 3'd2;
    push_front(3'd1);
    check("t2_count3", 32'(count),   32'd3);
    check("t2_pos0b",  32'(pos0Mem), 32'd1);
    idle();
    check("t2_dir",    32'(down_up_Flag), 32'd0);

    // 3: duplicate at back is dropped, contents unchanged
    push_back(3'd3);
    check("t3_drop",   32'(callDropped), 32'd1);
    check("t3_count",  32'(count),       32'd3);
    idle();
    check("t3_drop_1cyc", 32'(callDropped), 32'd0);
    exp_q = {3'd1, 3'd3, 3'd5};
    drain("t3_drain");
    // last pop emptied the queue; direction held from head 5 > floor 2
    check("t3_dir_hold", 32'(down_up_Flag), 32'd1);
    // empty queue: call for the current floor is dropped
    push_back(3'd2);
    check("t3_cur_drop",  32'(callDropped), 32'd1);
    check("t3_cur_count", 32'(count),       32'd0);
    push_back(3'd4);
    check("t3_ok_drop",   32'(callDropped), 32'd0);
    check("t3_ok_count",  32'(count),       32'd1);

    // 4: fill, full rejection, full with same-cycle pop
    do_reset();
    check("t4_rst_count", 32'(count), 32'd0);
    actualFloor = 3'd7;
    for (int f = 0; f < DEPTH; f++) push_back(3'(f));
    check("t4_count8", 32'(count),        32'd8);
    check("t4_full",   32'(memFull),      32'd1);
    check("t4_pos0",   32'(pos0Mem),      32'd0);
    check("t4_dir",    32'(down_up_Flag), 32'd0);
    push_back(3'd3);
    check("t4_fdrop",  32'(callDropped),  32'd1);
    check("t4_fcount", 32'(count),        32'd8);
    step(1'b1, MEM_END, 3'd0, 1'b1);
    check("t4_pp_drop",  32'(callDropped), 32'd0);
    check("t4_pp_count", 32'(count),       32'd8);
    check("t4_pp_full",  32'(memFull),     32'd1);
    check("t4_pp_pos0",  32'(pos0Mem),     32'd1);
    exp_q = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    drain("t4_drain");

    // 5: pop + push front at head 0, then wrap to head 7
    do_reset();
    actualFloor = 3'd0;
    push_back(3'd4);
    check("t5_pos0a", 32'(pos0Mem), 32'd4);
    step(1'b1, MEM_BEGIN, 3'd6, 1'b1);
    check("t5_count1", 32'(count),       32'd1);
    check("t5_pos0b",  32'(pos0Mem),     32'd6);
    check("t5_drop",   32'(callDropped), 32'd0);
    push_front(3'd2);
    check("t5_pos0c",  32'(pos0Mem),      32'd2);
    check("t5_count2", 32'(count),        32'd2);
    check("t5_dir",    32'(down_up_Flag), 32'd1);
    pop();
    check("t5_pos0d",  32'(pos0Mem), 32'd6);
    check("t5_count3", 32'(count),   32'd1);

    // 6: asynchronous reset mid-cycle with three entries and a pending pulse
    push_back(3'd1);
    push_back(3'd3);
    check("t6_count3", 32'(count), 32'd3);
    push_back(3'd6);
    check("t6_pre_drop", 32'(callDropped), 32'd1);
    #2;
    rst_n        = 1'b0;
    floorReached = 1'b1;
    #1;
    check("t6_async_count", 32'(count),        32'd0);
    check("t6_async_empty", 32'(memEmpty),     32'd1);
    check("t6_async_pos0",  32'(pos0Mem),      32'd0);
    check("t6_async_dir",   32'(down_up_Flag), 32'd0);
    check("t6_async_drop",  32'(callDropped),  32'd0);
    @(posedge clk);
    #1;
    check("t6_inrst_count", 32'(count), 32'd0);
    rst_n        = 1'b1;
    floorReached = 1'b0;
    @(posedge clk);
    #1;
    pop();
    check("t6_epop_count", 32'(count),       32'd0);
    check("t6_epop_empty", 32'(memEmpty),    32'd1);
    check("t6_epop_pos0",  32'(pos0Mem),     32'd0);
    check("t6_epop_drop",  32'(callDropped), 32'd0);
    push_back(3'd5);
    check("t6_after_pos0",  32'(pos0Mem), 32'd5);
    check("t6_after_count", 32'(count),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
